// File: rtl/btb_predictor_if.sv
// Fetch lookup and ID-stage resolution bundle for the branch target buffer.
// The predictor sits on the slave side; fetch/ID logic drives the master side.
interface btb_predictor_if #(
    parameter int XLEN = 32
);
    logic            enable;
    logic [XLEN-1:0] pc;
    logic            predicted;
    logic [XLEN-1:0] predicted_address;
    logic            upd_valid;
    logic [XLEN-1:0] upd_pc;
    logic            upd_taken;
    logic            upd_is_jump;
    logic [XLEN-1:0] upd_target;
    logic            flush_all;
    logic            upd_mispredict;

    modport master (
        output enable, pc, upd_valid, upd_pc, upd_taken, upd_is_jump, upd_target, flush_all,
        input  predicted, predicted_address, upd_mispredict
    );

    modport slave (
        input  enable, pc, upd_valid, upd_pc, upd_taken, upd_is_jump, upd_target, flush_all,
        output predicted, predicted_address, upd_mispredict
    );
endinterface

// File: rtl/btb_predictor.sv
// Direct-mapped BTB with 2-bit direction counters; lookup and mispredict are combinational,
// updates/flush/reset land on the next rising edge; no backpressure, one update per cycle.
module btb_predictor #(
    parameter int         XLEN     = 32,
    parameter int         ENTRIES  = 16,
    parameter logic [1:0] CNT_INIT = 2'b01
) (
    input  logic           clk_i,
    input  logic           rst_i,
    btb_predictor_if.slave btb
);
    localparam int IDX = $clog2(ENTRIES);
    localparam int TAG = XLEN - 2 - IDX;

    logic            valid_q  [ENTRIES];
    logic            valid_d  [ENTRIES];
    logic [TAG-1:0]  tag_q    [ENTRIES];
    logic [TAG-1:0]  tag_d    [ENTRIES];
    logic [XLEN-1:0] target_q [ENTRIES];
    logic [XLEN-1:0] target_d [ENTRIES];
    logic [1:0]      cnt_q    [ENTRIES];
    logic [1:0]      cnt_d    [ENTRIES];

    logic [IDX-1:0]  lk_idx;
    logic [TAG-1:0]  lk_tag;
    logic            lk_hit;
    logic [IDX-1:0]  up_idx;
    logic [TAG-1:0]  up_tag;
    logic            up_hit;
    logic            up_pred_t;
    logic [XLEN-1:0] up_pred_a;
    logic            unused_addr_lsbs;

    assign unused_addr_lsbs = ^{btb.pc[1:0], btb.upd_pc[1:0]};

    assign lk_idx = btb.pc[IDX+1:2];
    assign lk_tag = btb.pc[XLEN-1:IDX+2];
    assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

    assign btb.predicted         = lk_hit & cnt_q[lk_idx][1];
    assign btb.predicted_address = btb.predicted ? target_q[lk_idx] : btb.pc + XLEN'(4);

    // The resolving instruction is looked up against the same pre-update state as fetch.
    assign up_idx    = btb.upd_pc[IDX+1:2];
    assign up_tag    = btb.upd_pc[XLEN-1:IDX+2];
    assign up_hit    = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    assign up_pred_t = up_hit & cnt_q[up_idx][1];
    assign up_pred_a = up_pred_t ? target_q[up_idx] : btb.upd_pc + XLEN'(4);

    assign btb.upd_mispredict = btb.upd_valid &
                                ((up_pred_t != btb.upd_taken) |
                                 (up_pred_t & btb.upd_taken & (up_pred_a != btb.upd_target)));

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        cnt_d    = cnt_q;
        if (btb.enable) begin
            if (btb.flush_all) begin
                // Flush only drops valid bits; counters and targets stay for cheap reallocation.
                for (int i = 0; i < ENTRIES; i++) begin
                    valid_d[i] = 1'b0;
                end
            end else if (btb.upd_valid) begin
                if (up_hit) begin
                    if (btb.upd_is_jump) begin
                        cnt_d[up_idx]    = 2'd3;
                        target_d[up_idx] = btb.upd_target;
                    end else if (btb.upd_taken) begin
                        if (cnt_q[up_idx] != 2'd3) begin
                            cnt_d[up_idx] = cnt_q[up_idx] + 2'd1;
                        end
                        target_d[up_idx] = btb.upd_target;
                    end else if (cnt_q[up_idx] != 2'd0) begin
                        cnt_d[up_idx] = cnt_q[up_idx] - 2'd1;
                    end
                end else if (btb.upd_taken) begin
                    valid_d[up_idx]  = 1'b1;
                    tag_d[up_idx]    = up_tag;
                    target_d[up_idx] = btb.upd_target;
                    cnt_d[up_idx]    = btb.upd_is_jump ? 2'd3 : 2'd2;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= CNT_INIT;
            end
        end else begin
            valid_q  <= valid_d;
            tag_q    <= tag_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule
